dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// sitting between the memory stage and a word-wide backing memory.
// 16 lines x 4 words x 16 bits; per line valid, dirty and a 9-bit tag.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   Addr, DataIn, Rd, Wr   pipeline request (held stable while Stall=1)
//   DataOut, Done,         load data / completion pulse
//   Stall, CacheHit, err   pipeline freeze / hit indicator / illegal request
//   mem_addr, mem_wdata,   backing-memory word request, held until mem_ready
//   mem_rd, mem_wr
//   mem_ready, mem_rdata   backing-memory completion and read data
//
// state  | meaning
// IDLE   | serve hits with zero added latency, detect misses / illegal requests
// WB     | write the dirty victim line back, one word per mem_ready
// FILL   | read the requested line, one word per mem_ready
// FINISH | complete the original load/store from the freshly filled line
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WB, FILL, FINISH} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] valid;
  logic [15:0] dirty;
  logic [8:0]  tag_arr  [16];
  logic [15:0] data_arr [64];

  logic [8:0]  req_tag;
  logic [3:0]  idx;
  logic [1:0]  off;
  logic        req_ok;
  logic        req_bad;
  logic        hit;
  logic [15:0] line_word;

  assign req_tag   = Addr[15:7];
  assign idx       = Addr[6:3];
  assign off       = Addr[2:1];
  assign req_ok    = (Rd ^ Wr) & ~Addr[0];
  assign req_bad   = (Rd & Wr) | (Addr[0] & (Rd | Wr));
  assign hit       = valid[idx] && (tag_arr[idx] == req_tag);
  assign line_word = data_arr[{idx, off}];

  // Hits must complete in the request cycle, so the handshake outputs are
  // decoded from the state register and the live request.
  always_comb begin
    DataOut   = 16'h0000;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        err = req_bad;
        if (req_ok) begin
          if (hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            DataOut  = Rd ? line_word : 16'h0000;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      WB: begin
        Stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_arr[idx], idx, cnt, 1'b0};
        mem_wdata = data_arr[{idx, cnt}];
      end
      FILL: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {req_tag, idx, cnt, 1'b0};
      end
      FINISH: begin
        Done    = 1'b1;
        DataOut = Rd ? line_word : 16'h0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            if (hit) begin
              if (Wr) dirty[idx] <= 1'b1;
            end else begin
              cnt   <= 2'd0;
              state <= (valid[idx] && dirty[idx]) ? WB : FILL;
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[idx] <= 1'b1;
              dirty[idx] <= 1'b0;
              state      <= FINISH;
            end
          end
        end
        FINISH: begin
          if (Wr) dirty[idx] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage is not cleared by reset; only valid/dirty are.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && req_ok && hit && Wr)
        data_arr[{idx, off}] <= DataIn;
      if (state == FILL && mem_ready) begin
        data_arr[{idx, cnt}] <= mem_rdata;
        if (cnt == 2'd3) tag_arr[idx] <= req_tag;
      end
      if (state == FINISH && Wr)
        data_arr[{idx, off}] <= DataIn;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // backing memory seen on the bus, and the architectural memory a program sees
  logic [15:0] bmem    [32768];
  logic [15:0] ref_mem [32768];
  // residency model: which memory block each line holds
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [8:0]  m_tag   [16];

  logic [32:0] expq[$];
  logic [32:0] obsq[$];
  int ready_mode = 0;
  int cyc = 0;
  int both_err = 0;
  int stab_err = 0;
  int nonstall = 0;
  int last_stalls = 0;
  bit prev_pend = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  assign mem_rdata = bmem[mem_addr[15:1]];

  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = (cyc % 3 == 0);
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk) begin
    if (mem_rd && mem_wr) both_err++;
    if ((mem_rd || mem_wr) && prev_pend && mem_addr !== prev_addr) stab_err++;
    prev_pend = (mem_rd || mem_wr) && !mem_ready;
    prev_addr = mem_addr;
    if (mem_ready && mem_wr) begin
      obsq.push_back({1'b1, mem_addr, mem_wdata});
      bmem[mem_addr[15:1]] = mem_wdata;
    end
    if (mem_ready && mem_rd) obsq.push_back({1'b0, mem_addr, 16'h0000});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    // dirty lines are lost: what a program sees is now the backing memory
    for (int i = 0; i < 32768; i++) ref_mem[i] = bmem[i];
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input int mode);
    logic [3:0]  idx;
    logic [8:0]  tg;
    logic [14:0] widx;
    logic [14:0] vidx;
    bit          wb;
    idx  = a[6:3];
    tg   = a[15:7];
    widx = a[15:1];
    @(negedge clk);
    ready_mode = mode;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    #1;
    if ((rd && wr) || (a[0] && (rd || wr))) begin
      chk("illegal_err", err, 1'b1);
      chk("illegal_stall", Stall, 1'b0);
      chk("illegal_done", Done, 1'b0);
      obsq.delete();
      @(posedge clk);
      #1;
      chk("illegal_bus", obsq.size(), 0);
      return;
    end
    if (!rd && !wr) begin
      chk("noreq_flags", {err, Stall, Done}, 3'b000);
      @(posedge clk);
      return;
    end
    chk("legal_err", err, 1'b0);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      chk("hit_done", Done, 1'b1);
      chk("hit_flag", CacheHit, 1'b1);
      chk("hit_stall", Stall, 1'b0);
      if (rd) chk("hit_data", DataOut, ref_mem[widx]);
      @(posedge clk);
      if (wr) begin ref_mem[widx] = d; m_dirty[idx] = 1'b1; end
      return;
    end
    expq.delete();
    wb = m_valid[idx] && m_dirty[idx];
    if (wb)
      for (int k = 0; k < 4; k++) begin
        vidx = {m_tag[idx], idx, 2'(k)};
        expq.push_back({1'b1, vidx, 1'b0, ref_mem[vidx]});
      end
    for (int k = 0; k < 4; k++)
      expq.push_back({1'b0, tg, idx, 2'(k), 1'b0, 16'h0000});
    chk("miss_stall", Stall, 1'b1);
    chk("miss_done", Done, 1'b0);
    obsq.delete();
    last_stalls = 0;
    for (int c = 0; c < 400; c++) begin
      if (Done) break;
      if (!Stall) nonstall++;
      last_stalls++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    if (!Done) begin
      chk("miss_timeout", 0, 1);
      return;
    end
    chk("fin_hitflag", CacheHit, 1'b0);
    chk("fin_stall", Stall, 1'b0);
    if (rd) chk("fin_data", DataOut, ref_mem[widx]);
    if (mode == 0) chk("miss_latency", last_stalls, wb ? 9 : 5);
    chk("bus_count", obsq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < obsq.size(); k++)
      chk("bus_xfer", obsq[k], expq[k]);
    @(posedge clk);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    m_dirty[idx] = wr;
    if (wr) ref_mem[widx] = d;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
    do_reset();
    #1;
    chk("reset_outputs",
        {DataOut, Done, Stall, CacheHit, err, mem_rd, mem_wr, mem_addr, mem_wdata},
        '0);

    // cold load, then the same load hits
    bmem[16'h0104 >> 1] = 16'hBEEF;
    ref_mem[16'h0104 >> 1] = 16'hBEEF;
    do_access(1, 0, 16'h0104, 16'h0000, 0);
    do_access(1, 0, 16'h0104, 16'h0000, 0);
    // store hit, then a conflicting load evicts the dirty line
    do_access(0, 1, 16'h0104, 16'h1234, 0);
    do_access(1, 0, 16'h0184, 16'h0000, 0);
    chk("evict_wrote_back", bmem[16'h0104 >> 1], 16'h1234);
    do_access(1, 0, 16'h0104, 16'h0000, 0);

    // illegal requests
    do_access(1, 1, 16'h0010, 16'h0000, 0);
    do_access(1, 0, 16'h0011, 16'h0000, 0);
    do_access(0, 1, 16'h0011, 16'h5555, 0);
    do_access(0, 0, 16'h0010, 16'h0000, 0);

    // slow memory: ready every third cycle
    do_reset();
    do_access(1, 0, 16'h0104, 16'h0000, 1);
    chk("slow_latency_min", last_stalls >= 11, 1'b1);

    // reset in the middle of a fill, after two words
    do_reset();
    @(negedge clk);
    ready_mode = 0;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0104;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; Rd = 1'b0;
    #1;
    chk("abort_mem_rd", {mem_rd, mem_wr}, 2'b00);
    chk("abort_flags", {Stall, Done}, 2'b00);
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    for (int i = 0; i < 32768; i++) ref_mem[i] = bmem[i];
    do_access(1, 0, 16'h0104, 16'h0000, 0);

    // random traffic over a few conflicting tags
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a;
      int op;
      a = {7'(($urandom_range(0, 3)) << 0), 9'h000};
      a = {a[15:9] >> 0, 9'h000};
      a[15:7] = 9'($urandom_range(0, 3));
      a[6:3]  = 4'($urandom_range(0, 3));
      a[2:1]  = 2'($urandom_range(0, 3));
      a[0]    = ($urandom_range(0, 15) == 0);
      op = $urandom_range(0, 9);
      if (op == 0)      do_access(1, 1, a, 16'($urandom), $urandom_range(0, 2));
      else if (op < 6)  do_access(1, 0, a, 16'h0000, $urandom_range(0, 2));
      else              do_access(0, 1, a, 16'($urandom), $urandom_range(0, 2));
    end

    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    chk("rd_wr_exclusive", both_err, 0);
    chk("addr_stable", stab_err, 0);
    chk("stall_during_miss", nonstall, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
